divisor_secuencial: RTL and testbench

DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

---
 rtl/divisor_secuencial_pkg.sv | 15 +
 rtl/divisor_secuencial_if.sv | 27 ++
 rtl/divisor_secuencial_div_paso.sv | 27 ++
 rtl/divisor_secuencial.sv | 128 ++++++++++++
 tb/tb_divisor_secuencial.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/divisor_secuencial_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the default operand width.
package divisor_pkg;

    localparam int DIV_WIDTH = 32;

    // Controller states; IDLE must stay the all-zero encoding used at reset.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/divisor_secuencial_if.sv
// Request/result bundle of the sequential divider. The master drives the
// operands and Start; the slave (the divider) returns the results.
interface divisor_secuencial_if #(
    parameter int WIDTH = divisor_pkg::DIV_WIDTH
) ();

    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] Num;
    logic [WIDTH-1:0] Den;
    logic [WIDTH-1:0] Coc;
    logic [WIDTH-1:0] Res;
    logic             Done;
    logic             Busy;
    logic             DivZero;

    modport master (
        output Start, Signed, Num, Den,
        input  Coc, Res, Done, Busy, DivZero
    );

    modport slave (
        input  Start, Signed, Num, Den,
        output Coc, Res, Done, Busy, DivZero
    );

endinterface

// File: rtl/divisor_secuencial_div_paso.sv
// One restoring shift-subtract step on unsigned magnitudes.
// The partial remainder is always below the divisor, so after the shift it
// fits in WIDTH+1 bits; the top bit of the trial difference is the borrow.
module div_paso #(
    parameter int WIDTH = divisor_pkg::DIV_WIDTH
) (
    input  logic [WIDTH-1:0] accu,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] accu_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // Shift {accu,q} left, trial-subtract the divisor, keep it if no borrow.
    always_comb begin
        shifted   = {accu, q[WIDTH-1]};
        diff      = shifted - {1'b0, m};
        fits      = ~diff[WIDTH];
        accu_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next    = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle signed/unsigned integer divider. Operands are converted to
// magnitudes, divided with one restoring step per clock, then sign-corrected.
// Result registers hold their value between Done pulses.
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                CLK,
    input  logic                RSTa,
    divisor_secuencial_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_reg;
    logic [WIDTH-1:0] accu_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] coc_reg;
    logic [WIDTH-1:0] res_reg;
    logic             done_reg;
    logic             busy_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] accu_step;
    logic [WIDTH-1:0] q_step;

    // Absolute value as an unsigned WIDTH-bit number; the most negative
    // input maps to 2^(WIDTH-1), which is still representable.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sg);
        return (sg && v[WIDTH-1]) ? -v : v;
    endfunction

    div_paso #(.WIDTH(WIDTH)) u_paso (
        .accu      (accu_reg),
        .q         (q_reg),
        .m         (m_reg),
        .accu_next (accu_step),
        .q_next    (q_step)
    );

    // Controller, datapath and result registers.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_reg    <= IDLE;
            accu_reg     <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            coc_reg      <= '0;
            res_reg      <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.Start) begin
                        busy_reg  <= 1'b1;
                        neg_q_reg <= bus.Signed & (bus.Num[WIDTH-1] ^ bus.Den[WIDTH-1]);
                        neg_r_reg <= bus.Signed & bus.Num[WIDTH-1];
                        m_reg     <= magnitude(bus.Den, bus.Signed);
                        cnt_reg   <= CNT_W'(WIDTH - 1);
                        if (bus.Den == '0) begin
                            // Divide by zero: quotient saturates, remainder is
                            // |Num| so the remainder sign fix restores Num.
                            zero_reg  <= 1'b1;
                            q_reg     <= '1;
                            accu_reg  <= magnitude(bus.Num, bus.Signed);
                            state_reg <= FIX;
                        end else begin
                            zero_reg  <= 1'b0;
                            q_reg     <= magnitude(bus.Num, bus.Signed);
                            accu_reg  <= '0;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    accu_reg <= accu_step;
                    q_reg    <= q_step;
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (neg_q_reg && !zero_reg) begin
                        q_reg <= -q_reg;
                    end
                    if (neg_r_reg) begin
                        accu_reg <= -accu_reg;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    coc_reg      <= q_reg;
                    res_reg      <= accu_reg;
                    div_zero_reg <= zero_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.Coc     = coc_reg;
    assign bus.Res     = res_reg;
    assign bus.Done    = done_reg;
    assign bus.Busy    = busy_reg;
    assign bus.DivZero = div_zero_reg;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: a 32-bit and an 8-bit instance,
// hand-computed expected results, latency and Busy checks per operation.
module tb_divisor_secuencial;

    logic clk;
    logic rsta;

    int n_vec  = 0;
    int n_miss = 0;

    divisor_secuencial_if #(.WIDTH(32)) a ();
    divisor_secuencial_if #(.WIDTH(8))  b ();

    divisor_secuencial #(.WIDTH(32)) u32 (.CLK(clk), .RSTa(rsta), .bus(a));
    divisor_secuencial #(.WIDTH(8))  u8  (.CLK(clk), .RSTa(rsta), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One 32-bit operation: Start sampled at edge 0, Done expected at edge lat.
    task automatic op32(input logic sg, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] ec, input logic [31:0] er, input logic ez,
                        input int lat, input string tag);
        int  edges;
        bit  busy_ok;
        @(negedge clk);
        a.Start = 1'b1; a.Signed = sg; a.Num = n; a.Den = d;
        @(posedge clk); #1;
        a.Start = 1'b0; a.Num = ~n; a.Den = d + 32'd1;
        edges   = 0;
        busy_ok = (a.Busy === 1'b1);
        while (a.Done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (a.Done !== 1'b1 && a.Busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, ".lat"}, 64'(edges), 64'(lat));
        chk({tag, ".coc"}, 64'(a.Coc), 64'(ec));
        chk({tag, ".res"}, 64'(a.Res), 64'(er));
        chk({tag, ".dz"}, 64'(a.DivZero), 64'(ez));
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'(1));
        chk({tag, ".busy_done"}, 64'(a.Busy), 64'(0));
        $display("op32 %s: Num=0x%08h Den=0x%08h signed=%0d -> Coc=0x%08h Res=0x%08h DivZero=%0d edge %0d",
                 tag, n, d, sg, a.Coc, a.Res, a.DivZero, edges);
    endtask

    // One 8-bit operation; b2b launches Start in the current (Done) cycle.
    task automatic op8(input bit b2b, input logic sg, input logic [7:0] n, input logic [7:0] d,
                       input logic [7:0] ec, input logic [7:0] er, input int lat, input string tag);
        int  edges;
        bit  busy_ok;
        if (!b2b) @(negedge clk);
        b.Start = 1'b1; b.Signed = sg; b.Num = n; b.Den = d;
        @(posedge clk); #1;
        b.Start = 1'b0; b.Num = ~n; b.Den = d + 8'd1;
        edges   = 0;
        busy_ok = (b.Busy === 1'b1);
        while (b.Done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (b.Done !== 1'b1 && b.Busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, ".lat"}, 64'(edges), 64'(lat));
        chk({tag, ".coc"}, 64'(b.Coc), 64'(ec));
        chk({tag, ".res"}, 64'(b.Res), 64'(er));
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'(1));
        $display("op8 %s: Num=0x%02h Den=0x%02h signed=%0d -> Coc=0x%02h Res=0x%02h edge %0d",
                 tag, n, d, sg, b.Coc, b.Res, edges);
    endtask

    initial begin
        int  edges;
        bit  saw_done;

        rsta = 1'b0;
        a.Start = 1'b0; a.Signed = 1'b0; a.Num = '0; a.Den = '0;
        b.Start = 1'b0; b.Signed = 1'b0; b.Num = '0; b.Den = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.coc", 64'(a.Coc), 64'(0));
        chk("rst.res", 64'(a.Res), 64'(0));
        chk("rst.done", 64'(a.Done), 64'(0));
        chk("rst.busy", 64'(a.Busy), 64'(0));
        chk("rst.dz", 64'(a.DivZero), 64'(0));
        chk("rst8.coc", 64'(b.Coc), 64'(0));
        @(negedge clk);
        rsta = 1'b1;

        op32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, "u100_7");
        repeat (3) @(posedge clk);
        #1;
        chk("hold.coc", 64'(a.Coc), 64'(14));
        chk("hold.done", 64'(a.Done), 64'(0));

        op32(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, "s-7_2");
        op32(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, "s7_-2");
        op32(1'b0, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 2, "u55_0");
        repeat (3) @(posedge clk);
        #1;
        chk("hold.dz", 64'(a.DivZero), 64'(1));
        op32(1'b1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 2, "s55_0");
        op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, "s_ovf");
        op32(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, "u_max_1");

        // Start re-asserted at edge 5 of a running division must be ignored.
        @(negedge clk);
        a.Start = 1'b1; a.Signed = 1'b0; a.Num = 32'd1000; a.Den = 32'd10;
        @(posedge clk); #1;
        a.Start = 1'b0;
        edges = 0;
        repeat (4) begin @(posedge clk); #1; edges++; end
        a.Start = 1'b1; a.Num = 32'd9; a.Den = 32'd3;
        @(posedge clk); #1;
        edges++;
        a.Start = 1'b0;
        while (a.Done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("busy_start.lat", 64'(edges), 64'(34));
        chk("busy_start.coc", 64'(a.Coc), 64'(100));
        chk("busy_start.res", 64'(a.Res), 64'(0));
        $display("busy_start: Coc=0x%08h Res=0x%08h edge %0d", a.Coc, a.Res, edges);

        // Reset at edge 10 aborts the division without a Done pulse.
        @(negedge clk);
        a.Start = 1'b1; a.Num = 32'd1000; a.Den = 32'd10;
        @(posedge clk); #1;
        a.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rsta = 1'b0;
        #1;
        chk("abort.coc", 64'(a.Coc), 64'(0));
        chk("abort.res", 64'(a.Res), 64'(0));
        chk("abort.busy", 64'(a.Busy), 64'(0));
        chk("abort.done", 64'(a.Done), 64'(0));
        @(negedge clk);
        rsta = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (a.Done === 1'b1) saw_done = 1'b1;
        end
        chk("abort.no_done", 64'(saw_done), 64'(0));
        $display("abort: no Done seen after reset = %0d", !saw_done);
        op32(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, "u9_3");

        // 8-bit instance, including a Start issued in the Done cycle.
        op8(1'b0, 1'b0, 8'd200, 8'd13, 8'd15, 8'd5, 10, "w8_200_13");
        op8(1'b1, 1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 10, "w8_b2b");
        op8(1'b0, 1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE, 10, "w8_s-100_7");
        op8(1'b0, 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 10, "w8_ovf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
